// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry defaults, issue-state encoding and the
// buffered write entry type.
package vga_pkg;

  localparam int unsigned H_PIXELS = 50;
  localparam int unsigned V_PIXELS = 25;
  localparam int unsigned H_BITS   = 7;
  localparam int unsigned V_BITS   = 5;
  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned DATA_W   = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR
  } issue_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fb_wr_t;

endpackage

// File: rtl/vga_wr_fifo.sv
// Synchronous FIFO of frame-buffer write entries; push/pop are ignored when
// full/empty respectively.
module vga_wr_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  fb_wr_t                 din_i,
  input  logic                   pop_i,
  output fb_wr_t                 dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fb_wr_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads win whenever disp_ena is
// sampled high, buffered writes drain in the remaining cycles.
module vga_fb_arbiter #(
  parameter int unsigned H_PIXELS   = vga_pkg::H_PIXELS,
  parameter int unsigned V_PIXELS   = vga_pkg::V_PIXELS,
  parameter int unsigned H_BITS     = vga_pkg::H_BITS,
  parameter int unsigned V_BITS     = vga_pkg::V_BITS,
  parameter int unsigned ADDR_W     = vga_pkg::ADDR_W,
  parameter int unsigned DATA_W     = vga_pkg::DATA_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STALL_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        disp_ena,
  input  logic [H_BITS-1:0]           col,
  input  logic [V_BITS-1:0]           row,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        pix_valid,
  output logic [DATA_W-1:0]           pix_data,
  output logic                        frame_start,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [STALL_W-1:0]          wr_stall_cnt
);

  import vga_pkg::*;

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  if (H_PIXELS * V_PIXELS > 2**ADDR_W) begin : g_bad_geometry
    $error("frame buffer does not fit in ADDR_W address bits");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  issue_state_e      state_q, state_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wr_ready_q, rd_d1_q, pix_valid_q, frame_q;
  logic [DATA_W-1:0] pix_data_q;
  logic [STALL_W-1:0] stall_q;

  fb_wr_t            push_ent, head;
  logic              fifo_full, fifo_empty, push, pop;
  logic [LW-1:0]     level, level_next;

  assign push_ent   = '{addr: wr_addr, data: wr_data};
  assign push       = wr_valid && wr_ready_q && !fifo_full;
  assign pop        = !disp_ena && !fifo_empty;
  assign level_next = level + LW'(push) - LW'(pop);

  vga_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_ent),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  always_comb begin
    state_d     = S_IDLE;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (disp_ena) begin
      state_d    = S_RD;
      mem_en_d   = 1'b1;
      mem_addr_d = ADDR_W'(32'(row) * 32'(H_PIXELS) + 32'(col));
    end else if (!fifo_empty) begin
      state_d     = S_WR;
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = head.addr;
      mem_wdata_d = head.data;
    end
  end

  // pix_valid trails the read issue by two edges: RAM sample, then capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_ready_q  <= 1'b1;
      rd_d1_q     <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      frame_q     <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ready_q  <= (level_next != LW'(FIFO_DEPTH));
      rd_d1_q     <= (state_q == S_RD);
      pix_valid_q <= rd_d1_q;
      if (rd_d1_q) pix_data_q <= mem_rdata;
      frame_q     <= disp_ena && (row == '0) && (col == '0);
      if (wr_valid && !wr_ready_q && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

  assign wr_ready     = wr_ready_q;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign pix_valid    = pix_valid_q;
  assign pix_data     = pix_data_q;
  assign frame_start  = frame_q;
  assign fifo_level   = level;
  assign wr_stall_cnt = stall_q;

endmodule
